// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin arbiter of two masters onto internal regfile or timed external window
module regfile_access_arbiter #(
  parameter int AW = 11,
  parameter int DW = 32,
  parameter logic [AW-1:0] EXT_BASE = 11'h400,
  parameter int EXT_SIZE_LOG2 = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                     sysclk,
  input  logic                     sysrst_n,
  input  logic                     m0_req,
  input  logic                     m0_we,
  input  logic [AW-1:0]            m0_addr,
  input  logic [DW-1:0]            m0_wdata,
  input  logic [DW/8-1:0]          m0_be,
  output logic                     m0_ack,
  output logic [DW-1:0]            m0_rdata,
  output logic                     m0_err,
  input  logic                     m1_req,
  input  logic                     m1_we,
  input  logic [AW-1:0]            m1_addr,
  input  logic [DW-1:0]            m1_wdata,
  input  logic [DW/8-1:0]          m1_be,
  output logic                     m1_ack,
  output logic [DW-1:0]            m1_rdata,
  output logic                     m1_err,
  output logic                     reg_wr,
  output logic                     reg_rd,
  output logic [AW-1:0]            reg_addr,
  output logic [DW-1:0]            reg_wdata,
  output logic [DW/8-1:0]          reg_be,
  input  logic [DW-1:0]            reg_rdata,
  output logic                     ext_req,
  output logic                     ext_we,
  output logic [EXT_SIZE_LOG2-1:0] ext_addr,
  output logic [DW-1:0]            ext_wdata,
  output logic [DW/8-1:0]          ext_be,
  input  logic                     ext_ack,
  input  logic [DW-1:0]            ext_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_INT, S_INT_RSP, S_EXT, S_RSP} state_t;
  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              rsp;
  logic [DW-1:0]     rsp_data;
  logic              rsp_err;
  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: if (m0_req | m1_req) begin
        gnt_d   = (m0_req & m1_req) ? ~gnt_q : m1_req;
        we_d    = gnt_d ? m1_we : m0_we;
        addr_d  = gnt_d ? m1_addr : m0_addr;
        wdata_d = gnt_d ? m1_wdata : m0_wdata;
        be_d    = gnt_d ? m1_be : m0_be;
        state_d = (addr_d[AW-1:EXT_SIZE_LOG2] == EXT_BASE[AW-1:EXT_SIZE_LOG2]) ? S_EXT : S_INT;
      end
      S_INT: state_d = S_INT_RSP;
      S_INT_RSP, S_RSP: state_d = S_IDLE;
      S_EXT: if (ext_ack) begin
        rdata_d = we_q ? '0 : ext_rdata;
        err_d   = 1'b0;
        state_d = S_RSP;
      end else if (cnt_q == 16'(TIMEOUT - 1)) begin
        rdata_d = '0;
        err_d   = 1'b1;
        state_d = S_RSP;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    reg_wr    = (state_q == S_INT) & we_q;
    reg_rd    = (state_q == S_INT) & ~we_q;
    reg_addr  = addr_q;
    reg_wdata = wdata_q;
    reg_be    = be_q;
    ext_req   = state_q == S_EXT;
    ext_we    = we_q;
    ext_addr  = addr_q[EXT_SIZE_LOG2-1:0];
    ext_wdata = wdata_q;
    ext_be    = be_q;
    rsp       = (state_q == S_INT_RSP) | (state_q == S_RSP);
    rsp_data  = (state_q == S_INT_RSP) ? (we_q ? '0 : reg_rdata) : rdata_q;
    rsp_err   = (state_q == S_RSP) & err_q;
    m0_ack    = rsp & ~gnt_q;
    m1_ack    = rsp & gnt_q;
    m0_rdata  = m0_ack ? rsp_data : '0;
    m1_rdata  = m1_ack ? rsp_data : '0;
    m0_err    = m0_ack & rsp_err;
    m1_err    = m1_ack & rsp_err;
  end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: directed scoreboard bench for regfile_access_arbiter
module tb_regfile_access_arbiter;
  logic        clk = 1'b0;
  logic        sysrst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [10:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        reg_wr, reg_rd;
  logic [10:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata = 32'h0;
  logic        ext_req, ext_we;
  logic [9:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic [3:0]  ext_be;
  logic        ext_ack;
  logic [31:0] ext_rdata;
  typedef struct {logic m; logic [31:0] rd; logic err;} exp_t;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0, n_ack = 0, n_regwr = 0;
  regfile_access_arbiter dut (
    .sysclk(clk), .sysrst_n(sysrst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_be(reg_be), .reg_rdata(reg_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_be(ext_be), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );
  always #5 clk = ~clk;
  // register file model: read data tags the address so each master's read is distinguishable
  always @(posedge clk) if (reg_rd) reg_rdata <= 32'hA5A5_0000 | 32'(reg_addr >> 4);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic expect_rsp(input logic m, input logic [31:0] rd, input logic e);
    exp_t x;
    x.m = m; x.rd = rd; x.err = e;
    exp_q.push_back(x);
  endtask
  task automatic wait_acks(input int target);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (n_ack >= target) break;
    end
    if (n_ack < target) begin
      n_vec++; n_err++;
      $display("FAIL ack_wait: got %0d acks expected %0d", n_ack, target);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sysrst_n) begin
      if (reg_wr) n_regwr++;
      if (m0_ack || m1_ack) begin
        n_ack++;
        chk("single_ack", 64'(m0_ack & m1_ack), 64'(0));
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stray_ack: got m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
        end else begin
          e = exp_q.pop_front();
          chk("ack_master", 64'(m1_ack), 64'(e.m));
          chk("rdata", 64'(m1_ack ? m1_rdata : m0_rdata), 64'(e.rd));
          chk("err", 64'(m1_ack ? m1_err : m0_err), 64'(e.err));
          chk("loser_zero", 64'(m1_ack ? {m0_rdata, m0_err} : {m1_rdata, m1_err}), 64'(0));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, cnt;
    sysrst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h020; m0_wdata = '0; m0_be = 4'hF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h030; m1_wdata = '0; m1_be = 4'hF;
    ext_ack = 1'b0; ext_rdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'(|{m0_ack, m0_rdata, m0_err, m1_ack, m1_rdata, m1_err, reg_wr, reg_rd,
        reg_addr, reg_wdata, reg_be, ext_req, ext_we, ext_addr, ext_wdata, ext_be}), 64'(0));
    // both held from reset release: m0 first, then strict alternation
    expect_rsp(0, 32'hA5A5_0002, 0); expect_rsp(1, 32'hA5A5_0003, 0);
    expect_rsp(0, 32'hA5A5_0002, 0); expect_rsp(1, 32'hA5A5_0003, 0);
    @(posedge clk); #1 sysrst_n = 1'b1;
    wait_acks(4);
    #1 m0_req = 1'b0; m1_req = 1'b0;
    // internal read latency
    @(posedge clk); #1 m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h010;
    expect_rsp(0, 32'hA5A5_0001, 0);
    @(posedge clk); @(negedge clk);
    chk("int_strobe", 64'({reg_rd, reg_wr, m0_ack}), 64'(3'b100));
    chk("int_addr", 64'(reg_addr), 64'(11'h010));
    @(negedge clk);
    chk("int_ack_time", 64'(m0_ack), 64'(1));
    t = n_ack; wait_acks(t + 1);
    #1 m0_req = 1'b0;
    // external write, ack on 5th cycle
    t = n_regwr;
    @(posedge clk); #1 m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'h404; m1_wdata = 32'h1234_5678; m1_be = 4'b0011;
    expect_rsp(1, 32'h0, 0);
    @(posedge clk); @(negedge clk);
    chk("ext_req_on", 64'({ext_req, ext_we}), 64'(2'b11));
    chk("ext_addr", 64'(ext_addr), 64'(10'h004));
    chk("ext_be_wdata", 64'({ext_be, ext_wdata}), 64'({4'b0011, 32'h1234_5678}));
    repeat (4) @(posedge clk);
    #1 ext_ack = 1'b1;
    @(posedge clk); #1 ext_ack = 1'b0;
    @(negedge clk);
    chk("ext_wr_ack", 64'({m1_ack, ext_req}), 64'(2'b10));
    wait_acks(n_ack);
    #1 m1_req = 1'b0;
    chk("no_reg_wr", 64'(n_regwr), 64'(t));
    // external read timeout
    ext_rdata = 32'hCAFE_0000;
    @(posedge clk); #1 m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h7FC;
    expect_rsp(0, 32'h0, 1);
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!ext_req) break;
      cnt++;
    end
    chk("timeout_len", 64'(cnt), 64'(255));
    chk("timeout_ack", 64'(m0_ack), 64'(1));
    chk("timeout_addr", 64'(ext_addr), 64'(10'h3FC));
    wait_acks(n_ack);
    #1 m0_req = 1'b0;
    // ext_ack on the TIMEOUT-th cycle is a success
    ext_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1 m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h500;
    expect_rsp(1, 32'hDEAD_BEEF, 0);
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 300 && cnt < 254; i++) begin
      @(negedge clk);
      if (ext_req) cnt++;
    end
    @(posedge clk); #1 ext_ack = 1'b1;
    @(negedge clk);
    chk("ext_req_last", 64'(ext_req), 64'(1));
    @(posedge clk); #1 ext_ack = 1'b0;
    @(negedge clk);
    chk("edge_ack", 64'({m1_ack, ext_req}), 64'(2'b10));
    wait_acks(n_ack);
    #1 m1_req = 1'b0;
    // ext_ack outside EXT does nothing
    @(posedge clk); #1 ext_ack = 1'b1;
    @(posedge clk); #1 ext_ack = 1'b0;
    @(negedge clk);
    chk("stray_ext_ack", 64'({m0_ack, m1_ack, ext_req}), 64'(0));
    // reset during EXT aborts, pointer returns to m0-first
    @(posedge clk); #1 m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h400;
    @(posedge clk); @(negedge clk);
    chk("pre_reset_ext", 64'(ext_req), 64'(1));
    #2 sysrst_n = 1'b0;
    #1 chk("async_reset", 64'({ext_req, m0_ack, m1_ack}), 64'(0));
    m0_we = 1'b1; m0_addr = 11'h050; m0_wdata = 32'h77; m0_be = 4'hF;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 11'h060;
    expect_rsp(0, 32'h0, 0); expect_rsp(1, 32'hA5A5_0006, 0);
    t = n_ack;
    @(posedge clk); #1 sysrst_n = 1'b1;
    wait_acks(t + 2);
    #1 m0_req = 1'b0; m1_req = 1'b0;
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
